// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single register-file write port. ALU writeback always wins the
// port; multdiv results are buffered in a small FIFO and drained whenever the
// ALU is idle. If the FIFO is empty, a multdiv result bypasses the buffer.
// A younger ALU write to the same register squashes buffered entries (WAW).
// Decode can query buffered destinations for RAW hazards.
//
// Ports:
//   clock, ctrl_reset             clock / async active-high reset
//   alu_we, alu_rd, alu_data      ALU writeback (never stalls)
//   md_valid, md_rd, md_data      multdiv result offer
//   md_ready                      FIFO has space
//   ctrl_readRegA/B               hazard query addresses
//   hazard_A/B                    query matches a valid buffered entry
//   ctrl_writeEnable/WriteReg,
//   data_writeReg                 registered register-file write port
//   buf_count                     occupied FIFO entries
module regfile_write_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                   clock,
   input  logic                   ctrl_reset,
   input  logic                   alu_we,
   input  logic [ADDR_W-1:0]      alu_rd,
   input  logic [DATA_W-1:0]      alu_data,
   input  logic                   md_valid,
   input  logic [ADDR_W-1:0]      md_rd,
   input  logic [DATA_W-1:0]      md_data,
   output logic                   md_ready,
   input  logic [ADDR_W-1:0]      ctrl_readRegA,
   input  logic [ADDR_W-1:0]      ctrl_readRegB,
   output logic                   hazard_A,
   output logic                   hazard_B,
   output logic                   ctrl_writeEnable,
   output logic [ADDR_W-1:0]      ctrl_writeReg,
   output logic [DATA_W-1:0]      data_writeReg,
   output logic [$clog2(DEPTH):0] buf_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // FIFO storage and pointers
   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [ADDR_W-1:0] rd_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Write-port output registers
   logic              we_q, we_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic alu_wr, md_xfer, md_live, fifo_empty;
   logic do_pop, do_bypass, do_push;

   assign md_ready         = (count_q < CNT_W'(DEPTH));
   assign buf_count        = count_q;
   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;

   always_comb begin
      alu_wr     = alu_we && (alu_rd != '0);
      md_xfer    = md_valid && md_ready;
      // r0 transfers are consumed without buffering or writing
      md_live    = md_xfer && (md_rd != '0);
      fifo_empty = (count_q == '0);
      do_pop     = !alu_wr && !fifo_empty;
      do_bypass  = !alu_wr && fifo_empty && md_live;
      do_push    = md_live && !do_bypass;
   end

   // Port selection: ALU, then FIFO head, then bypass
   always_comb begin
      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if (alu_wr) begin
         we_d    = 1'b1;
         wreg_d  = alu_rd;
         wdata_d = alu_data;
      end else if (!fifo_empty) begin
         // A squashed head is still freed but issues no write
         if (vld_q[rd_ptr_q]) begin
            we_d    = 1'b1;
            wreg_d  = rd_q[rd_ptr_q];
            wdata_d = data_q[rd_ptr_q];
         end
      end else if (md_live) begin
         we_d    = 1'b1;
         wreg_d  = md_rd;
         wdata_d = md_data;
      end
   end

   // FIFO next state. Valid bits of free entries are always kept at zero so the
   // hazard and squash logic can scan every slot without occupancy masking.
   always_comb begin
      vld_d    = vld_q;
      rd_d     = rd_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (alu_wr) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == alu_rd) vld_d[i] = 1'b0;
         end
      end
      if (do_pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      // Applied after the squash so a same-edge push is never squashed
      if (do_push) begin
         vld_d[wr_ptr_q]  = 1'b1;
         rd_d[wr_ptr_q]   = md_rd;
         data_d[wr_ptr_q] = md_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end

      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Hazard query against valid buffered destinations
   always_comb begin
      hazard_A = 1'b0;
      hazard_B = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (rd_q[i] == ctrl_readRegA) && (ctrl_readRegA != '0)) hazard_A = 1'b1;
         if (vld_q[i] && (rd_q[i] == ctrl_readRegB) && (ctrl_readRegB != '0)) hazard_B = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rd_q     <= rd_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (DEPTH=4, ADDR_W=5, DATA_W=32).
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        alu_we;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   logic [4:0]  ctrl_readRegA, ctrl_readRegB;
   logic        hazard_A, hazard_B;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [2:0]  buf_count;

   int n_pass = 0;
   int n_total = 0;

   regfile_write_arbiter #(
      .DEPTH (4),
      .ADDR_W(5),
      .DATA_W(32)
   ) dut (
      .clock           (clock),
      .ctrl_reset      (ctrl_reset),
      .alu_we          (alu_we),
      .alu_rd          (alu_rd),
      .alu_data        (alu_data),
      .md_valid        (md_valid),
      .md_rd           (md_rd),
      .md_data         (md_data),
      .md_ready        (md_ready),
      .ctrl_readRegA   (ctrl_readRegA),
      .ctrl_readRegB   (ctrl_readRegB),
      .hazard_A        (hazard_A),
      .hazard_B        (hazard_B),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .data_writeReg   (data_writeReg),
      .buf_count       (buf_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] d);
      check({tag, ".we"}, 64'(ctrl_writeEnable), 64'(we));
      check({tag, ".rd"}, 64'(ctrl_writeReg), 64'(rd));
      check({tag, ".data"}, 64'(data_writeReg), 64'(d));
   endtask

   initial begin
      ctrl_reset    = 1'b1;
      alu_we        = 1'b0;
      alu_rd        = '0;
      alu_data      = '0;
      md_valid      = 1'b0;
      md_rd         = '0;
      md_data       = '0;
      ctrl_readRegA = '0;
      ctrl_readRegB = '0;
      #1;
      check_wr("reset", 1'b0, 5'd0, 32'h0);
      check("reset.count", 64'(buf_count), 64'd0);
      check("reset.ready", 64'(md_ready), 64'd1);
      check("reset.hazA", 64'(hazard_A), 64'd0);
      tick();
      @(negedge clock);
      ctrl_reset = 1'b0;

      // ALU writes on consecutive cycles
      alu_we = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
      tick();
      check_wr("alu_r5", 1'b1, 5'd5, 32'h11);
      check("alu_r5.ready", 64'(md_ready), 64'd1);
      alu_rd = 5'd6; alu_data = 32'h22;
      tick();
      check_wr("alu_r6", 1'b1, 5'd6, 32'h22);
      alu_we = 1'b0;
      tick();
      check_wr("idle_hold", 1'b0, 5'd6, 32'h22);

      // Bypass when FIFO empty
      md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hDEAD;
      tick();
      check_wr("bypass", 1'b1, 5'd10, 32'hDEAD);
      check("bypass.count", 64'(buf_count), 64'd0);
      md_valid = 1'b0;
      tick();

      // Fill FIFO while ALU owns the port; r15 held until space frees
      ctrl_readRegA = 5'd13;
      ctrl_readRegB = 5'd15;
      begin
         int md_idx;
         md_idx = 11;
         for (int k = 0; k < 6; k++) begin
            alu_we   = 1'b1;
            alu_rd   = 5'(k + 1);
            alu_data = 32'h100 + 32'(k);
            md_valid = 1'b1;
            md_rd    = 5'(md_idx);
            md_data  = 32'hA000 + 32'(md_idx);
            tick();
            if (k < 4) md_idx++;
            check_wr($sformatf("fill%0d", k), 1'b1, 5'(k + 1), 32'h100 + 32'(k));
            check($sformatf("fill%0d.count", k), 64'(buf_count), 64'((k < 3) ? k + 1 : 4));
            check($sformatf("fill%0d.ready", k), 64'(md_ready), 64'(k < 3));
         end
      end
      check("fill.hazA_r13", 64'(hazard_A), 64'd1);
      check("fill.hazB_r15", 64'(hazard_B), 64'd0);

      // Drain in order; r15 accepted on the second drain edge
      alu_we = 1'b0;
      tick();
      check_wr("drain11", 1'b1, 5'd11, 32'hA00B);
      check("drain11.count", 64'(buf_count), 64'd3);
      tick();
      md_valid = 1'b0;
      check_wr("drain12", 1'b1, 5'd12, 32'hA00C);
      check("drain12.count", 64'(buf_count), 64'd3);
      check("drain12.hazB_r15", 64'(hazard_B), 64'd1);
      tick();
      check_wr("drain13", 1'b1, 5'd13, 32'hA00D);
      check("drain13.count", 64'(buf_count), 64'd2);
      tick();
      check_wr("drain14", 1'b1, 5'd14, 32'hA00E);
      tick();
      check_wr("drain15", 1'b1, 5'd15, 32'hA00F);
      check("drain15.count", 64'(buf_count), 64'd0);
      check("drain15.hazB", 64'(hazard_B), 64'd0);
      tick();
      check("drained.we", 64'(ctrl_writeEnable), 64'd0);

      // WAW squash: buffered r12=5 overwritten by ALU r12=9
      alu_we = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h5;
      ctrl_readRegA = 5'd12;
      tick();
      md_valid = 1'b0;
      check_wr("waw_alu7", 1'b1, 5'd7, 32'h77);
      check("waw.count", 64'(buf_count), 64'd1);
      check("waw.haz_before", 64'(hazard_A), 64'd1);
      alu_rd = 5'd12; alu_data = 32'h9;
      tick();
      check_wr("waw_alu12", 1'b1, 5'd12, 32'h9);
      check("waw.haz_after", 64'(hazard_A), 64'd0);
      check("waw.count_after", 64'(buf_count), 64'd1);
      alu_we = 1'b0;
      tick();
      check_wr("waw_drain", 1'b0, 5'd12, 32'h9);
      check("waw_drain.count", 64'(buf_count), 64'd0);

      // Register-0 filtering
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h77;
      ctrl_readRegA = 5'd0;
      tick();
      check("r0_md.we", 64'(ctrl_writeEnable), 64'd0);
      check("r0_md.count", 64'(buf_count), 64'd0);
      check("r0_md.hazA", 64'(hazard_A), 64'd0);
      alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      tick();
      check_wr("r0_md_alu3", 1'b1, 5'd3, 32'h33);
      check("r0_md_alu3.count", 64'(buf_count), 64'd0);
      md_valid = 1'b0;
      alu_rd = 5'd0; alu_data = 32'h44;
      tick();
      check_wr("alu_r0", 1'b0, 5'd3, 32'h33);

      // Asynchronous reset with two buffered entries
      alu_we = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      md_valid = 1'b1; md_rd = 5'd20; md_data = 32'h20;
      ctrl_readRegA = 5'd20;
      tick();
      alu_rd = 5'd2; alu_data = 32'h2;
      md_rd = 5'd21; md_data = 32'h21;
      tick();
      alu_we = 1'b0;
      md_valid = 1'b0;
      check("rst_pre.count", 64'(buf_count), 64'd2);
      check("rst_pre.hazA", 64'(hazard_A), 64'd1);
      #2;
      ctrl_reset = 1'b1;
      #1;
      check_wr("async_rst", 1'b0, 5'd0, 32'h0);
      check("async_rst.count", 64'(buf_count), 64'd0);
      check("async_rst.hazA", 64'(hazard_A), 64'd0);
      check("async_rst.ready", 64'(md_ready), 64'd1);
      tick();
      @(negedge clock);
      ctrl_reset = 1'b0;
      tick();
      check_wr("post_rst1", 1'b0, 5'd0, 32'h0);
      tick();
      check_wr("post_rst2", 1'b0, 5'd0, 32'h0);
      check("post_rst.count", 64'(buf_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
